// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor D = A - B - bin, one 4-bit borrow-lookahead slice per clock.
// Optional macro SUB_SAT_EN: unsigned saturation of the final difference to zero on borrow-out.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int NSL = WIDTH / 4;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic             r_borrow;
    logic             r_bout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [CW+1:0]    w_sh;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [3:0]       w_a_sl;
    logic [3:0]       w_b_sl;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_c;
    logic [3:0]       w_sum;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_d_next;
    logic             w_ovf;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign d         = r_d;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

    // Current-slice borrow lookahead: subtraction as a + ~b + ~borrow
    always_comb begin
        w_accept = in_valid & r_in_ready;
        w_last   = (r_cnt == CW'(NSL - 1));
        w_sh     = {r_cnt, 2'b00};
        w_a_sh   = r_a >> w_sh;
        w_b_sh   = r_b >> w_sh;
        w_a_sl   = w_a_sh[3:0];
        w_b_sl   = w_b_sh[3:0];
        w_g      = w_a_sl & ~w_b_sl;
        w_p      = w_a_sl ^ ~w_b_sl;
        w_c[0]   = ~r_borrow;
        w_c[1]   = w_g[0] | (w_p[0] & w_c[0]);
        w_c[2]   = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
        w_c[3]   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        w_c[4]   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        w_sum    = w_p ^ w_c[3:0];
        w_mask   = {{(WIDTH-4){1'b0}}, 4'hF} << w_sh;
        w_d_next = (r_d & ~w_mask) | ({{(WIDTH-4){1'b0}}, w_sum} << w_sh);
        // On the last slice w_sum[3] is the unsaturated result MSB
        w_ovf    = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_sum[3] ^ r_a[WIDTH-1]);
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == DONE);
        end
    end

    // Operand capture and per-slice datapath update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_d      <= {WIDTH{1'b0}};
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= {CW{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    r_d      <= w_d_next;
                    r_borrow <= ~w_c[4];
                    r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (w_last) begin
                        r_bout <= ~w_c[4];
                        r_ovf  <= w_ovf;
`ifdef SUB_SAT_EN
                        if (!w_c[4]) begin
                            r_d <= {WIDTH{1'b0}};
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor (WIDTH=16), honours SUB_SAT_EN.
module tb_nibble_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d;
    logic        bout;
    logic        ovf;

    int n_tests;
    int n_fail;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present operands for one edge; checks they were taken.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin);
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("accept_in_ready_low", {31'd0, in_ready}, 32'd0);
    endtask

    // Wait for result, check latency and values.
    task automatic wait_check(input string tag, input logic [15:0] ed, input logic eb, input logic eo);
        int lat;
        logic [15:0] ed_s;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        ed_s = ed;
`ifdef SUB_SAT_EN
        if (eb) ed_s = 16'h0000;
`endif
        check_val({tag, "_lat"}, lat, 32'd4);
        check_val({tag, "_d"}, {16'd0, d}, {16'd0, ed_s});
        check_val({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
        check_val({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    endtask

    task automatic release_out(input int stall);
        for (int i = 0; i < stall; i++) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("release_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                      input logic tbin, input logic [15:0] ed, input logic eb, input logic eo);
        issue(ta, tb_v, tbin);
        wait_check(tag, ed, eb, eo);
        release_out(0);
    endtask

    initial begin
        logic [16:0] ref_diff;
        logic [15:0] ra, rb, hold_d;
        logic        rbin, rovf;

        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0000; b = 16'h0000; bin = 1'b0;
        #23;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_d", {16'd0, d}, 32'd0);
        check_val("rst_bout", {31'd0, bout}, 32'd0);
        check_val("rst_ovf", {31'd0, ovf}, 32'd0);

        op("wrap",     16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        op("ovf_min",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        op("ovf_a5",   16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1);
        op("eq_bin1",  16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        op("eq_bin0",  16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
        op("small",    16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0);
        op("max_neg1", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        op("ffff_b1",  16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op("nib_chain",16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);

        // Backpressure: result held while new operands are offered
        issue(16'h0100, 16'h0001, 1'b0);
        wait_check("bp", 16'h00FF, 1'b0, 1'b0);
        hold_d = d;
        @(negedge clk);
        a = 16'h4444; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_val("bp_d_hold", {16'd0, d}, {16'd0, hold_d});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("bp_new_taken", {31'd0, in_ready}, 32'd0);
        wait_check("bp_new", 16'h3333, 1'b0, 1'b0);
        release_out(0);

        // Reset in the middle of RUN discards the operation
        issue(16'h0000, 16'h0001, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst_d", {16'd0, d}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_val("midrst_no_result", {31'd0, out_valid}, 32'd0);

        // Random operands against an arithmetic reference, with random stalls
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom_range(1, 0));
            ref_diff = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
            rovf = (ra[15] != rb[15]) && (ref_diff[15] != ra[15]);
            issue(ra, rb, rbin);
            wait_check("rand", ref_diff[15:0], ref_diff[16], rovf);
            release_out($urandom_range(3, 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
